// File: rtl/gb_oam_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : gb_oam_dma_if
//  Brief    : Start request, source-bus and OAM-write signals of the OAM DMA.
//  Revision : 1.0  initial release
// ============================================================================
interface gb_oam_dma_if;
    logic        dma_start;
    logic [15:0] dma_start_addr;
    logic        dma_rd;
    logic [15:0] dma_src_addr;
    logic [7:0]  dma_rdata;
    logic        oam_we;
    logic [7:0]  oam_waddr;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    // DMA engine side
    modport master (
        input  dma_start,
        input  dma_start_addr,
        input  dma_rdata,
        output dma_rd,
        output dma_src_addr,
        output oam_we,
        output oam_waddr,
        output oam_wdata,
        output dma_active
    );

    // Register block / system bus / OAM side
    modport slave (
        output dma_start,
        output dma_start_addr,
        output dma_rdata,
        input  dma_rd,
        input  dma_src_addr,
        input  oam_we,
        input  oam_waddr,
        input  oam_wdata,
        input  dma_active
    );
endinterface
`default_nettype wire

// File: rtl/gb_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : gb_oam_dma
//  Brief    : OAM DMA engine, copies 160 bytes from {page,00..9F} into OAM.
//  Revision : 1.0  initial release
// ============================================================================
module gb_oam_dma #(
    parameter int NUM_BYTES     = 160,
    parameter int STARTUP_TCYC  = 4,
    parameter int TCYC_PER_BYTE = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    gb_oam_dma_if.master  bus
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_startup = 2'd1;
    localparam logic [1:0] c_st_xfer    = 2'd2;

    localparam logic [2:0] c_startup_last = 3'(STARTUP_TCYC - 1);
    localparam logic [1:0] c_phase_last   = 2'(TCYC_PER_BYTE - 1);
    localparam logic [7:0] c_idx_last     = 8'(NUM_BYTES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_start_q;
    logic [7:0]  r_page;
    logic [7:0]  w_page_nxt;
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_nxt;
    logic [1:0]  r_t;
    logic [1:0]  w_t_nxt;
    logic [2:0]  r_scnt;
    logic [2:0]  w_scnt_nxt;

    logic        w_start;
    logic [7:0]  w_page_in;
    logic        w_unused_addr_lo;

    logic        w_rd;
    logic [15:0] w_src_addr;
    logic        w_we;
    logic [7:0]  w_waddr;
    logic [7:0]  w_wdata;

    assign w_start          = bus.dma_start & ~r_start_q;
    assign w_unused_addr_lo = ^bus.dma_start_addr[7:0];

    // Pages E0..FF alias the echo-RAM mirror of work RAM
    assign w_page_in = (bus.dma_start_addr[15:8] >= 8'hE0)
                     ? (bus.dma_start_addr[15:8] & 8'hDF)
                     : bus.dma_start_addr[15:8];

    // The edge detector also samples during reset, so a level held through
    // reset is not mistaken for a fresh request afterwards.
    always_ff @(posedge clk) begin
        r_start_q <= bus.dma_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_t     <= 2'd0;
            r_scnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_page  <= w_page_nxt;
            r_idx   <= w_idx_nxt;
            r_t     <= w_t_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_idx_nxt   = r_idx;
        w_t_nxt     = r_t;
        w_scnt_nxt  = r_scnt;
        w_rd        = 1'b0;
        w_src_addr  = 16'h0000;
        w_we        = 1'b0;
        w_waddr     = 8'h00;
        w_wdata     = 8'h00;

        if (r_state == c_st_xfer) begin
            w_rd       = 1'b1;
            w_src_addr = {r_page, r_idx};
        end

        if (w_start) begin
            // A new edge in any state (re)starts the copy; any pending
            // write of the aborted copy is dropped.
            w_state_nxt = c_st_startup;
            w_page_nxt  = w_page_in;
            w_idx_nxt   = 8'h00;
            w_t_nxt     = 2'd0;
            w_scnt_nxt  = 3'd0;
        end else begin
            case (r_state)
                c_st_startup: begin
                    if (r_scnt == c_startup_last) begin
                        w_state_nxt = c_st_xfer;
                        w_idx_nxt   = 8'h00;
                        w_t_nxt     = 2'd0;
                        w_scnt_nxt  = 3'd0;
                    end else begin
                        w_scnt_nxt = r_scnt + 3'd1;
                    end
                end
                c_st_xfer: begin
                    if (r_t == c_phase_last) begin
                        w_we    = 1'b1;
                        w_waddr = r_idx;
                        w_wdata = bus.dma_rdata;
                        w_t_nxt = 2'd0;
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = c_st_idle;
                            w_idx_nxt   = 8'h00;
                        end else begin
                            w_idx_nxt = r_idx + 8'd1;
                        end
                    end else begin
                        w_t_nxt = r_t + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    assign bus.dma_rd       = w_rd;
    assign bus.dma_src_addr = w_src_addr;
    assign bus.oam_we       = w_we;
    assign bus.oam_waddr    = w_waddr;
    assign bus.oam_wdata    = w_wdata;
    assign bus.dma_active   = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_gb_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_oam_dma
//  Brief    : Directed self-checking bench for the OAM DMA engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gb_oam_dma;

    localparam int c_maxc = 1000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    gb_oam_dma_if bus ();

    gb_oam_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  mem [0:65535];
    logic        rec_act   [0:c_maxc];
    logic        rec_rd    [0:c_maxc];
    logic [15:0] rec_src   [0:c_maxc];
    logic        rec_we    [0:c_maxc];
    logic [7:0]  rec_waddr [0:c_maxc];
    logic [7:0]  rec_wdata [0:c_maxc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dma_rdata = mem[bus.dma_src_addr];

    // Page C1 yields i ^ 5A; other pages differ so a wrong page is visible
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9B;
    endfunction

    task automatic sample(input int c);
        rec_act[c]   = bus.dma_active;
        rec_rd[c]    = bus.dma_rd;
        rec_src[c]   = bus.dma_src_addr;
        rec_we[c]    = bus.oam_we;
        rec_waddr[c] = bus.oam_waddr;
        rec_wdata[c] = bus.oam_wdata;
    endtask

    // Cycle 0 is the start edge; inputs change 1 after posedge, sampled at negedge
    task automatic observe(input int ncyc, input int hold, input logic [15:0] addr,
                           input int rs_cyc, input logic [15:0] rs_addr, input int rst_cyc);
        @(posedge clk); #1;
        bus.dma_start      = 1'b1;
        bus.dma_start_addr = addr;
        reset              = 1'b0;
        @(negedge clk); sample(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.dma_start = (c < hold) || (c == rs_cyc);
            if (c == rs_cyc) bus.dma_start_addr = rs_addr;
            reset = (c == rst_cyc);
            @(negedge clk); sample(c);
        end
    endtask

    function automatic int count_we(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (rec_we[c]) n++;
        return n;
    endfunction

    task automatic test_reset;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.dma_start = 1'b0;
        bus.dma_start_addr = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.dma_active !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %b expected 0", bus.dma_active); end
        n_checks++;
        if (bus.dma_rd !== 1'b0) begin n_errors++; $display("FAIL reset_rd: got %b expected 0", bus.dma_rd); end
        n_checks++;
        if (bus.dma_src_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_src: got %h expected 0000", bus.dma_src_addr); end
        n_checks++;
        if (bus.oam_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b expected 0", bus.oam_we); end
        n_checks++;
        if ({bus.oam_waddr, bus.oam_wdata} !== 16'h0000) begin n_errors++; $display("FAIL reset_wbus: got %h expected 0000", {bus.oam_waddr, bus.oam_wdata}); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_basic;
        int k;
        int low_cnt;
        observe(660, 1, 16'hC100, -1, 16'h0000, -1);
        n_checks++;
        if (count_we(0, 660) !== 160) begin n_errors++; $display("FAIL basic_count: got %0d expected 160", count_we(0, 660)); end
        k = 0;
        for (int c = 0; c <= 660; c++) begin
            if (rec_we[c]) begin
                n_checks++;
                if (c !== 8 + 4 * k || rec_waddr[c] !== 8'(k) || rec_wdata[c] !== (8'(k) ^ 8'h5A)) begin
                    n_errors++;
                    $display("FAIL basic_write%0d: got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, c, rec_waddr[c], rec_wdata[c], 8 + 4 * k, 8'(k), 8'(k) ^ 8'h5A);
                end
                k++;
            end
        end
        low_cnt = 0;
        for (int c = 1; c <= 644; c++) if (!rec_act[c]) low_cnt++;
        n_checks++;
        if (rec_act[0] !== 1'b0) begin n_errors++; $display("FAIL basic_act0: got %b expected 0", rec_act[0]); end
        n_checks++;
        if (low_cnt !== 0) begin n_errors++; $display("FAIL basic_act_span: got %0d low cycles expected 0", low_cnt); end
        n_checks++;
        if (rec_act[645] !== 1'b0 || rec_rd[645] !== 1'b0) begin n_errors++; $display("FAIL basic_end: got act %b rd %b expected 0 0", rec_act[645], rec_rd[645]); end
        n_checks++;
        if (rec_rd[4] !== 1'b0 || rec_rd[5] !== 1'b1) begin n_errors++; $display("FAIL basic_rd_start: got %b%b expected 01", rec_rd[4], rec_rd[5]); end
    endtask

    task automatic test_held;
        int bad;
        observe(660, 4, 16'h8000, -1, 16'h0000, -1);
        n_checks++;
        if (count_we(0, 660) !== 160) begin n_errors++; $display("FAIL held_count: got %0d expected 160", count_we(0, 660)); end
        bad = 0;
        for (int c = 5; c <= 644; c++)
            if (rec_src[c] !== 16'h8000 + 16'((c - 5) / 4) || rec_rd[c] !== 1'b1) bad++;
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL held_src_sweep: got %0d bad cycles expected 0", bad); end
        n_checks++;
        if (rec_wdata[8] !== src_byte(16'h8000)) begin n_errors++; $display("FAIL held_first_data: got %h expected %h", rec_wdata[8], src_byte(16'h8000)); end
    endtask

    task automatic test_echo;
        observe(660, 1, 16'hFE00, -1, 16'h0000, -1);
        n_checks++;
        if (count_we(0, 660) !== 160) begin n_errors++; $display("FAIL echo_count: got %0d expected 160", count_we(0, 660)); end
        n_checks++;
        if (rec_src[5] !== 16'hDE00) begin n_errors++; $display("FAIL echo_src_first: got %h expected DE00", rec_src[5]); end
        n_checks++;
        if (rec_src[644] !== 16'hDE9F) begin n_errors++; $display("FAIL echo_src_last: got %h expected DE9F", rec_src[644]); end
        n_checks++;
        if (rec_wdata[644] !== src_byte(16'hDE9F)) begin n_errors++; $display("FAIL echo_last_data: got %h expected %h", rec_wdata[644], src_byte(16'hDE9F)); end
    endtask

    task automatic test_restart;
        int first_after;
        int last_we;
        int low_cnt;
        observe(760, 1, 16'hC000, 100, 16'hD000, -1);
        n_checks++;
        if (rec_we[100] !== 1'b0) begin n_errors++; $display("FAIL restart_no_write: got %b expected 0", rec_we[100]); end
        first_after = -1;
        last_we = -1;
        for (int c = 760; c > 100; c--) if (rec_we[c]) first_after = c;
        for (int c = 0; c <= 760; c++) if (rec_we[c]) last_we = c;
        n_checks++;
        if (first_after !== 108) begin n_errors++; $display("FAIL restart_next_cyc: got %0d expected 108", first_after); end
        n_checks++;
        if (rec_waddr[108] !== 8'h00 || rec_wdata[108] !== src_byte(16'hD000) || rec_src[108] !== 16'hD000) begin
            n_errors++;
            $display("FAIL restart_next_write: got addr %h data %h src %h expected 00 %h D000",
                     rec_waddr[108], rec_wdata[108], rec_src[108], src_byte(16'hD000));
        end
        low_cnt = 0;
        for (int c = 1; c <= 744; c++) if (!rec_act[c]) low_cnt++;
        n_checks++;
        if (low_cnt !== 0 || rec_act[745] !== 1'b0) begin n_errors++; $display("FAIL restart_active: got %0d low cycles, act745 %b expected 0, 0", low_cnt, rec_act[745]); end
        n_checks++;
        if (count_we(0, 760) !== 183 || last_we !== 744) begin n_errors++; $display("FAIL restart_total: got %0d writes last %0d expected 183 last 744", count_we(0, 760), last_we); end
    endtask

    task automatic test_reset_mid;
        int bad;
        observe(320, 1, 16'hC100, -1, 16'h0000, 300);
        bad = 0;
        for (int c = 301; c <= 320; c++)
            if (rec_act[c] || rec_rd[c] || rec_we[c] || rec_src[c] != 16'h0 || rec_waddr[c] != 8'h0 || rec_wdata[c] != 8'h0) bad++;
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL reset_mid_quiet: got %0d busy cycles expected 0", bad); end
        observe(660, 1, 16'hC100, -1, 16'h0000, -1);
        n_checks++;
        if (count_we(0, 660) !== 160) begin n_errors++; $display("FAIL reset_mid_recopy: got %0d expected 160", count_we(0, 660)); end
        n_checks++;
        if (rec_waddr[644] !== 8'h9F || rec_wdata[644] !== 8'hC5) begin n_errors++; $display("FAIL reset_mid_last: got %h/%h expected 9F/C5", rec_waddr[644], rec_wdata[644]); end
    endtask

    task automatic test_reset_held;
        int busy;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.dma_start = 1'b1;
        bus.dma_start_addr = 16'hC100;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.dma_active || bus.oam_we || bus.dma_rd) busy++;
        end
        n_checks++;
        if (busy !== 0) begin n_errors++; $display("FAIL held_reset_idle: got %0d busy cycles expected 0", busy); end
        @(posedge clk); #1;
        bus.dma_start = 1'b0;
        observe(20, 1, 16'hC100, -1, 16'h0000, -1);
        n_checks++;
        if (rec_act[1] !== 1'b1 || rec_we[8] !== 1'b1 || rec_wdata[8] !== 8'h5A) begin
            n_errors++;
            $display("FAIL held_reset_restart: got act %b we %b data %h expected 1 1 5A", rec_act[1], rec_we[8], rec_wdata[8]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.dma_start = 1'b0;
        bus.dma_start_addr = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[a] = src_byte(16'(a));
        test_reset();
        test_basic();
        test_held();
        test_echo();
        test_restart();
        test_reset_mid();
        test_reset_held();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
